// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings for the EX-stage divider issue controller: FSM states,
// divider handshake levels, stall-request levels and the zero word.
package div_issue_ctrl_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    localparam logic STALL    = 1'b1;
    localparam logic NO_STALL = 1'b0;

    localparam logic [DIV_DATA_W-1:0] ZERO_WORD = '0;

    function automatic logic is_zero_word(input logic [DIV_DATA_W-1:0] w);
        return w == ZERO_WORD;
    endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Bus between the issue controller (master) and the multi-cycle divider (slave).
interface div_issue_if #(
    parameter int DATA_W = 32
) ();

    logic                  div_start_o;
    logic                  div_signed_o;
    logic [DATA_W-1:0]     div_op1_o;
    logic [DATA_W-1:0]     div_op2_o;
    logic [2*DATA_W-1:0]   div_result_i;
    logic                  div_ready_i;

    modport master (
        output div_start_o,
        output div_signed_o,
        output div_op1_o,
        output div_op2_o,
        input  div_result_i,
        input  div_ready_i
    );

    modport slave (
        input  div_start_o,
        input  div_signed_o,
        input  div_op1_o,
        input  div_op2_o,
        output div_result_i,
        output div_ready_i
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle DIV/DIVU unit: issues, stalls, writes HI/LO, drains on flush.
// Optional build macro DIV_ZERO_SKIP_EN: a zero divisor bypasses the divider and leaves HI/LO untouched.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic              flush_i,
    div_issue_if.master       div_bus,
    output logic              stall_req_o,
    output logic              hilo_we_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              busy_o
);

    div_state_e        state_q;
    div_state_e        state_d;

    logic              div_signed_q;
    logic [DATA_W-1:0] div_op1_q;
    logic [DATA_W-1:0] div_op2_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              skip_q;

    logic              start;
    logic              stall;
    logic              hilo_we;
    logic              latch_ops;
    logic              capture;
    logic              zero_skip;
    logic              ready;

    assign ready = (div_bus.div_ready_i == DIV_RESULT_READY);

`ifdef DIV_ZERO_SKIP_EN
    assign zero_skip = is_zero_word(DIV_DATA_W'(op2_i));
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start     = DIV_STOP;
        stall     = NO_STALL;
        hilo_we   = 1'b0;
        latch_ops = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    stall     = STALL;
                    latch_ops = 1'b1;
                    state_d   = zero_skip ? DONE : WAIT;
                end
            end
            WAIT: begin
                start = DIV_START;
                stall = STALL;
                if (flush_i) begin
                    // A result arriving with the flush already lets the divider go free.
                    state_d = ready ? IDLE : DRAIN;
                end else if (ready) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Dropping start here is what releases the divider from its end state.
                hilo_we = !flush_i && !skip_q;
                state_d = IDLE;
            end
            DRAIN: begin
                start = DIV_START;
                stall = req_valid_i ? STALL : NO_STALL;
                if (div_bus.div_ready_i != DIV_RESULT_NOT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst) begin
            stall   = NO_STALL;
            hilo_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_signed_q <= 1'b0;
            div_op1_q    <= DATA_W'(ZERO_WORD);
            div_op2_q    <= DATA_W'(ZERO_WORD);
            skip_q       <= 1'b0;
            hi_q         <= DATA_W'(ZERO_WORD);
            lo_q         <= DATA_W'(ZERO_WORD);
        end else begin
            if (latch_ops) begin
                div_signed_q <= signed_i;
                div_op1_q    <= op1_i;
                div_op2_q    <= op2_i;
                skip_q       <= zero_skip;
            end
            if (capture) begin
                hi_q <= div_bus.div_result_i[2*DATA_W-1:DATA_W];
                lo_q <= div_bus.div_result_i[DATA_W-1:0];
            end
        end
    end

    assign div_bus.div_start_o  = start;
    assign div_bus.div_signed_o = div_signed_q;
    assign div_bus.div_op1_o    = div_op1_q;
    assign div_bus.div_op2_o    = div_op2_q;

    assign stall_req_o = stall;
    assign hilo_we_o   = hilo_we;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider that raises ready 5 cycles after start.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        signed_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic        flush_i;
    logic        stall_req_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    div_issue_if #(.DATA_W(32)) dbus ();

    div_issue_ctrl #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .signed_i    (signed_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .flush_i     (flush_i),
        .div_bus     (dbus),
        .stall_req_o (stall_req_o),
        .hilo_we_o   (hilo_we_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Divider stand-in: holds ready and result until start is released.
    function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    logic [2:0] mdl_cnt;
    always @(posedge clk) begin
        if (rst || !dbus.div_start_o) begin
            mdl_cnt           <= 3'd0;
            dbus.div_ready_i  <= 1'b0;
            dbus.div_result_i <= 64'd0;
        end else if (!dbus.div_ready_i) begin
            if (mdl_cnt == 3'd4) begin
                dbus.div_ready_i  <= 1'b1;
                dbus.div_result_i <= div_ref(dbus.div_signed_o, dbus.div_op1_o, dbus.div_op2_o);
            end else begin
                mdl_cnt <= mdl_cnt + 3'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full issue from IDLE through WAIT (6 cycles with this divider) and DONE, back to IDLE.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el);
        req_valid_i = 1'b1;
        signed_i    = s;
        op1_i       = a;
        op2_i       = b;
        #1;
        chk({tag, ".idle_stall"}, stall_req_o, 1);
        chk({tag, ".idle_start"}, dbus.div_start_o, 0);
        tick();
        signed_i = ~s;
        op1_i    = ~a;
        op2_i    = ~b;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk({tag, ".wait_start"}, dbus.div_start_o, 1);
            chk({tag, ".wait_stall"}, stall_req_o, 1);
            chk({tag, ".wait_signed"}, dbus.div_signed_o, s);
            chk({tag, ".wait_op1"}, dbus.div_op1_o, a);
            chk({tag, ".wait_op2"}, dbus.div_op2_o, b);
            chk({tag, ".wait_we"}, hilo_we_o, 0);
            tick();
        end
        chk({tag, ".done_we"}, hilo_we_o, 1);
        chk({tag, ".done_hi"}, hi_o, eh);
        chk({tag, ".done_lo"}, lo_o, el);
        chk({tag, ".done_start"}, dbus.div_start_o, 0);
        chk({tag, ".done_stall"}, stall_req_o, 0);
        chk({tag, ".done_busy"}, busy_o, 1);
        req_valid_i = 1'b0;
        tick();
        chk({tag, ".idle_we"}, hilo_we_o, 0);
        chk({tag, ".idle_busy"}, busy_o, 0);
        chk({tag, ".idle_start2"}, dbus.div_start_o, 0);
        chk({tag, ".hold_hi"}, hi_o, eh);
        chk({tag, ".hold_lo"}, lo_o, el);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_i = 1'b1;
        signed_i    = 1'b1;
        op1_i       = 32'h1234_5678;
        op2_i       = 32'h9;
        flush_i     = 1'b0;
        #1;
        chk("rst_stall_during", stall_req_o, 0);
        tick();
        tick();
        chk("rst_stall", stall_req_o, 0);
        chk("rst_start", dbus.div_start_o, 0);
        chk("rst_signed", dbus.div_signed_o, 0);
        chk("rst_op1", dbus.div_op1_o, 0);
        chk("rst_op2", dbus.div_op2_o, 0);
        chk("rst_we", hilo_we_o, 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_busy", busy_o, 0);
        req_valid_i = 1'b0;
        rst         = 1'b0;
        tick();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
        run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        run_div("b2b_10_3", 1'b0, 32'd10, 32'd3, 32'd1, 32'd3);
        run_div("b2b_9_2", 1'b0, 32'd9, 32'd2, 32'd1, 32'd4);

        // A flushed request in IDLE never starts anything.
        req_valid_i = 1'b1;
        flush_i     = 1'b1;
        op1_i       = 32'd50;
        op2_i       = 32'd5;
        #1;
        chk("idle_flush_stall", stall_req_o, 0);
        tick();
        chk("idle_flush_busy", busy_o, 0);
        chk("idle_flush_start", dbus.div_start_o, 0);
        flush_i = 1'b0;

        // Flush on the 3rd WAIT cycle: drain the divider, discard the result.
        signed_i = 1'b0;
        #1;
        tick();
        tick();
        tick();
        flush_i     = 1'b1;
        req_valid_i = 1'b0;
        #1;
        chk("flush_wait_stall", stall_req_o, 1);
        chk("flush_wait_we", hilo_we_o, 0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("drain_busy", busy_o, 1);
        chk("drain_start", dbus.div_start_o, 1);
        chk("drain_stall_noreq", stall_req_o, 0);
        chk("drain_we", hilo_we_o, 0);
        req_valid_i = 1'b1;
        #1;
        chk("drain_stall_req", stall_req_o, 1);
        req_valid_i = 1'b0;
        tick();
        chk("drain_start_c2", dbus.div_start_o, 1);
        tick();
        chk("drain_start_ready", dbus.div_start_o, 1);
        chk("drain_busy_ready", busy_o, 1);
        chk("drain_we_ready", hilo_we_o, 0);
        tick();
        chk("drain_exit_busy", busy_o, 0);
        chk("drain_exit_start", dbus.div_start_o, 0);
        chk("drain_exit_we", hilo_we_o, 0);
        chk("drain_hi_kept", hi_o, 32'd1);
        chk("drain_lo_kept", lo_o, 32'd4);
        tick();
        chk("late_ready_ignored", busy_o, 0);

`ifdef DIV_ZERO_SKIP_EN
        req_valid_i = 1'b1;
        signed_i    = 1'b0;
        op1_i       = 32'd100;
        op2_i       = 32'd0;
        #1;
        chk("dz_skip_idle_stall", stall_req_o, 1);
        chk("dz_skip_idle_start", dbus.div_start_o, 0);
        tick();
        chk("dz_skip_done_start", dbus.div_start_o, 0);
        chk("dz_skip_done_we", hilo_we_o, 0);
        chk("dz_skip_done_stall", stall_req_o, 0);
        chk("dz_skip_done_busy", busy_o, 1);
        req_valid_i = 1'b0;
        tick();
        chk("dz_skip_idle_busy", busy_o, 0);
        chk("dz_skip_hi", hi_o, 32'd1);
        chk("dz_skip_lo", lo_o, 32'd4);
`else
        run_div("div_by_zero", 1'b0, 32'd100, 32'd0, 32'd0, 32'd0);
`endif

        // Reset in the middle of WAIT.
        req_valid_i = 1'b1;
        signed_i    = 1'b1;
        op1_i       = 32'd77;
        op2_i       = 32'd7;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("midrst_pre_busy", busy_o, 1);
        rst = 1'b1;
        #1;
        chk("midrst_stall_during", stall_req_o, 0);
        tick();
        chk("midrst_start", dbus.div_start_o, 0);
        chk("midrst_signed", dbus.div_signed_o, 0);
        chk("midrst_op1", dbus.div_op1_o, 0);
        chk("midrst_op2", dbus.div_op2_o, 0);
        chk("midrst_we", hilo_we_o, 0);
        chk("midrst_hi", hi_o, 0);
        chk("midrst_lo", lo_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_stall", stall_req_o, 0);
        rst = 1'b0;
        tick();

        run_div("post_rst_1000_30", 1'b0, 32'd1000, 32'd30, 32'd10, 32'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
